one_vote: RTL and testbench
===========================

ONE_VOTE -- requirements
Module: one_vote

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, range 1..15: consecutive identical input samples required before a vote vector is accepted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rolla  input  1  voter A ballot (1 = yes, 0 = no).
REQ-005 rollb  input  1  voter B ballot.
REQ-006 rollc  input  1  voter C ballot.
REQ-007 volps  output  1  pass by simple majority: at least two of three accepted votes are 1.
REQ-008 volpc  output  1  pass by consensus: all three accepted votes are 1.
REQ-009 vold  output  1  disagreement: accepted votes not all equal.
REQ-010 volb  output  1  blank: all three accepted votes are 0.
REQ-011 vote_count  output  2  number of 1s in accepted vote vector (0..3).
REQ-012 upd  output  1  one-cycle pulse when the accepted vector changes value.

Function
REQ-013 Input vector V = {rolla, rollb, rollc}, sampled into register S on every rising edge; inputs assumed synchronous to clk.
REQ-014 Stability counter C (4 bits): if V != S at an edge, C <= 1; else C <= min(C+1, STABLE_CYCLES).
- Net effect: C is the number of consecutive identical samples of S.
REQ-015 Accepted vector A <= S on the edge where C == STABLE_CYCLES and S != A; otherwise A holds.
REQ-016 All outputs are registered decodes of A and update one edge after A changes.
- Latency: a stable input change reaches the outputs STABLE_CYCLES+2 edges after the input is first sampled.
REQ-017 Decode rules on A:
- vote_count = popcount(A).
- volps = (vote_count >= 2).
- volpc = (vote_count == 3).
- volb = (vote_count == 0).
- vold = (vote_count is 1 or 2).
REQ-018 Invariants at every cycle outside reset:
- volpc implies volps.
- volb implies !volps.
- vold == !(volpc | volb).
- Exactly one of {volb, volpc, vold} is 1.
REQ-019 upd = 1 for exactly the one cycle in which the outputs first reflect a new A; 0 otherwise.
REQ-020 Glitch rejection: an input pattern held fewer than STABLE_CYCLES samples never changes A or the outputs.
- The counter restarts on the new pattern.
REQ-021 Re-asserting a pattern equal to the current A produces no upd pulse and no output change.

Reset
REQ-022 While rst = 1 at an edge: S = 000, C = 0, A = 000.
- Outputs: volb = 1, volps = 0, volpc = 0, vold = 0, vote_count = 0, upd = 0.
REQ-023 Reset mid-operation discards any partially-stable pattern.
- Acceptance restarts from C = 0 on the first edge after rst deasserts.
REQ-024 The first edge after deassertion samples V normally.

Structure
REQ-025 Package one_vote_pkg:
- Typedef vote_vec_t (3 bits).
- Function popcount3.
- Constant CNT_W = 4.
REQ-026 Sub-module one_vote_filter:
- Holds S, C and A.
- Emits A plus an accept strobe.
- Top level instantiates it and holds the decode and output registers.

Verification (STABLE_CYCLES = 2)
REQ-027 Reset for 2 cycles -> volb = 1, vold = 0, volps = 0, volpc = 0, vote_count = 0, upd = 0.
REQ-028 Sweep V = 000..111, each held 10 cycles -> outputs after settling:
- 000 -> volb = 1.
- 001, 010, 100 -> vold = 1, count = 1.
- 011, 101, 110 -> volps = 1, vold = 1, count = 2.
- 111 -> volps = 1, volpc = 1, count = 3.
- One upd pulse per change.
REQ-029 From accepted 000, apply V = 111 for 1 cycle then 000 -> outputs unchanged, no upd.
REQ-030 From accepted 000, apply V = 110 held -> volps = 1 and upd = 1 on the 4th edge after the first sample of 110, not earlier.
REQ-031 Assert rst while V = 111 is still being qualified -> after release with V = 111 held, acceptance takes the full STABLE_CYCLES+2 edges.
REQ-032 Checker on every cycle: REQ-018 invariants hold, and vote_count equals popcount of the applied vector once settled.

Source files
------------

// File: rtl/one_vote_pkg.sv
// one_vote_pkg: shared types, counter width and vote decode helpers for one_vote.
package one_vote_pkg;

    localparam int CNT_W = 4;

    typedef logic [2:0] vote_vec_t;

    typedef struct packed {
        logic       volps;
        logic       volpc;
        logic       vold;
        logic       volb;
        logic [1:0] count;
    } vote_dec_t;

    function automatic logic [1:0] popcount3(input vote_vec_t v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // count 1 or 2 is exactly the case where the two count bits differ
    function automatic vote_dec_t decode_vote(input vote_vec_t v);
        logic [1:0] n;
        n = popcount3(v);
        return '{volps: n[1], volpc: &n, vold: ^n, volb: n == 2'd0, count: n};
    endfunction

endpackage

// File: rtl/one_vote_if.sv
// one_vote_if: ballot inputs and decoded vote results.
//   rolla/rollb/rollc : voter A/B/C ballots (master -> slave)
//   volps/volpc/vold/volb/vote_count/upd : registered results (slave -> master)
interface one_vote_if;

    logic       rolla;
    logic       rollb;
    logic       rollc;
    logic       volps;
    logic       volpc;
    logic       vold;
    logic       volb;
    logic [1:0] vote_count;
    logic       upd;

    modport master (
        output rolla, rollb, rollc,
        input  volps, volpc, vold, volb, vote_count, upd
    );

    modport slave (
        input  rolla, rollb, rollc,
        output volps, volpc, vold, volb, vote_count, upd
    );

endinterface

// File: rtl/one_vote_filter.sv
// one_vote_filter: debounces the ballot vector and publishes the accepted vector.
//   clk, rst  : clock, synchronous active-high reset
//   v_i       : raw ballot vector {a, b, c}
//   a_o       : accepted vector
//   accept_o  : high for the cycle after a_o takes a new value
module one_vote_filter
    import one_vote_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  vote_vec_t v_i,
    output vote_vec_t a_o,
    output logic      accept_o
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    vote_vec_t        s_q, s_d;
    vote_vec_t        a_q, a_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic             acc_q, acc_d;

    // c_q counts consecutive identical samples held in s_q, saturating at STABLE
    always_comb begin
        s_d   = v_i;
        c_d   = (v_i != s_q) ? CNT_W'(1) : (c_q >= STABLE) ? STABLE : c_q + CNT_W'(1);
        acc_d = (c_q == STABLE) && (s_q != a_q);
        a_d   = acc_d ? s_q : a_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            acc_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            c_q   <= c_d;
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign a_o      = a_q;
    assign accept_o = acc_q;

endmodule

// File: rtl/one_vote.sv
// one_vote: three-voter ballot with debounced inputs and registered vote decodes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : one_vote_if slave (ballots in, volps/volpc/vold/volb/vote_count/upd out)
module one_vote
    import one_vote_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    one_vote_if.slave bus
);

    vote_vec_t a;
    logic      accept;
    vote_dec_t dec_q, dec_d;
    logic      upd_q, upd_d;

    one_vote_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .v_i      ({bus.rolla, bus.rollb, bus.rollc}),
        .a_o      (a),
        .accept_o (accept)
    );

    // accept is high the cycle after a changes, so upd lines up with the new decode
    always_comb begin
        dec_d = decode_vote(a);
        upd_d = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= decode_vote('0);
            upd_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
            upd_q <= upd_d;
        end
    end

    assign bus.volps      = dec_q.volps;
    assign bus.volpc      = dec_q.volpc;
    assign bus.vold       = dec_q.vold;
    assign bus.volb       = dec_q.volb;
    assign bus.vote_count = dec_q.count;
    assign bus.upd        = upd_q;

endmodule

// File: tb/tb_one_vote.sv
// tb_one_vote: scoreboard bench for one_vote with STABLE_CYCLES = 2.
module tb_one_vote;

    localparam int SC = 2;

    typedef struct {
        logic [2:0] v;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_seen = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t       sb[$];
    logic [2:0] cur_exp = '0;
    logic [2:0] last_v = '0;
    logic [2:0] acc_model = '0;
    int         run_len = 0;

    one_vote_if bus ();

    one_vote #(
        .STABLE_CYCLES(SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // {volps, volpc, vold, volb, count}
    function automatic logic [5:0] expect_dec(input logic [2:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) n += int'(v[i]);
        return {n >= 2, n == 3, n == 1 || n == 2, n == 0, 2'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: a pattern sampled SC times in a row that differs from the last
    // accepted one shows up on the outputs two edges after its SC-th sample.
    task automatic step(input logic [2:0] v, input int n);
        repeat (n) begin
            {bus.rolla, bus.rollb, bus.rollc} = v;
            run_len = (v == last_v) ? run_len + 1 : 1;
            last_v  = v;
            if (run_len == SC && v != acc_model) begin
                sb.push_back('{v: v, at: cyc + 3});
                acc_model = v;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic [2:0] v, input int n);
        rst = 1'b1;
        {bus.rolla, bus.rollb, bus.rollc} = v;
        repeat (n) @(negedge clk);
        rst       = 1'b0;
        last_v    = '0;
        run_len   = 0;
        acc_model = '0;
    endtask

    always @(negedge clk) begin : monitor
        logic exp_upd;
        if (cyc > 0) begin
            exp_upd = 1'b0;
            if (rst_seen) begin
                sb.delete();
                cur_exp = '0;
            end else if (sb.size() > 0 && sb[0].at == cyc) begin
                cur_exp = sb.pop_front().v;
                exp_upd = 1'b1;
            end
            check("outputs", {bus.volps, bus.volpc, bus.vold, bus.volb, bus.vote_count},
                  expect_dec(cur_exp));
            check("upd", bus.upd, exp_upd);
            check("invariants", {bus.volpc & ~bus.volps, bus.volb & bus.volps,
                                 bus.vold == (bus.volpc | bus.volb),
                                 !$onehot({bus.volb, bus.volpc, bus.vold})}, 0);
        end
    end

    initial begin
        {bus.rolla, bus.rollb, bus.rollc} = 3'b000;
        do_reset(3'b000, 2);
        for (int i = 0; i < 8; i++) step(3'(i), 10);
        step(3'b000, 6);
        step(3'b111, 1);
        step(3'b000, 6);
        step(3'b110, 8);
        step(3'b010, 1);
        step(3'b110, 5);
        step(3'b000, 6);
        step(3'b111, 1);
        do_reset(3'b111, 2);
        step(3'b111, 8);
        for (int i = 0; i < 40; i++) step(3'($urandom_range(0, 7)), $urandom_range(1, 4));
        step(last_v, 6);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
